// File: rtl/i2c_target_if.sv
// i2c_target_if -- byte-side handshake bundle of the I2C target.
//
// Signals:
//   IDATA  [7:0]  byte the user offers for the next master read
//   IDRDY         one-cycle strobe, IDATA valid (loads TX holding register)
//   TREQ          TX holding register empty during an active read transfer
//   ODATA  [7:0]  last byte received on a master write
//   ODRDY         one-cycle pulse, ODATA updated
//   BUSY          target addressed, until STOP or repeated START
//   RW            R/W bit of the current addressed transfer (1 = master read)
//
// Modports: slave = the i2c_target side, master = the user/host side.
interface i2c_target_if;
    logic [7:0] IDATA;
    logic       IDRDY;
    logic       TREQ;
    logic [7:0] ODATA;
    logic       ODRDY;
    logic       BUSY;
    logic       RW;

    modport slave (
        input  IDATA, IDRDY,
        output TREQ, ODATA, ODRDY, BUSY, RW
    );

    modport master (
        output IDATA, IDRDY,
        input  TREQ, ODATA, ODRDY, BUSY, RW
    );
endinterface

// File: rtl/i2c_target.sv
// i2c_target -- 7-bit addressed I2C target (slave) with one-byte TX holding
// register and byte-wide receive output.
//
// Parameters:
//   TARGET_ADDR  7-bit address this target answers (default 7'h50)
//   SYNC_STAGES  synchronizer depth on SCL/SDA (2..4, default 2)
// Ports:
//   CLK          system clock, rising edge
//   NRST         asynchronous reset, active high
//   I2C_SCL      open-drain SCL (driven 0 or released to 'z')
//   I2C_SDA      open-drain SDA (driven 0 or released to 'z')
//   bus          i2c_target_if.slave: IDATA/IDRDY in, TREQ/ODATA/ODRDY/BUSY/RW out
// Build option:
//   I2C_TARGET_CLK_STRETCH_EN  when defined, SCL is held low at a read byte
//   load while the holding register is empty, until IDRDY supplies data.
//   When undefined, SCL is never driven and an empty holding register sends 8'hFF.
module i2c_target #(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        NRST,
    inout  wire         I2C_SCL,
    inout  wire         I2C_SDA,
    i2c_target_if.slave bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_DATA  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_DATA  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;

    logic [2:0]             r_state;
    logic [3:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic                   r_phase;
    logic                   r_sda_oe;
    logic                   r_scl_oe;
    logic [7:0]             r_odata;
    logic                   r_odrdy;
    logic                   r_busy;
    logic                   r_rw;
    logic [7:0]             r_hold;
    logic                   r_hold_full;

    logic                   w_load_req;
    logic                   w_hold_take;
    logic [7:0]             w_load_val;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    // 0: not stretching, 1: holding SCL waiting for data, 2: SDA setup cycle
    logic [1:0]             r_stretch;
`endif

    // Input synchronizers, reset to the idle (released) bus level.
    always_ff @(posedge CLK or posedge NRST) begin
        if (NRST) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], I2C_SCL};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], I2C_SDA};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    always_comb begin
        w_scl_rise = w_scl & ~r_scl_d;
        w_scl_fall = ~w_scl & r_scl_d;
        // SCL must be high on both samples so a coincident SCL/SDA change is not a START/STOP
        w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
        w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
        // Shift-register load point: SCL fall ending the address ACK (read) or an acked RD_ACK
        w_load_req = w_scl_fall & r_phase &
                     (((r_state == ST_ADDR_ACK) & r_rw) | (r_state == ST_RD_ACK));
        w_load_val = r_hold_full ? r_hold : 8'hFF;
        w_hold_take = w_load_req & r_hold_full;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        if ((r_state == ST_RD_DATA) && (r_stretch == 2'd1) && r_hold_full) begin
            w_hold_take = 1'b1;
        end
`endif
    end

    // TX holding register; a new IDRDY always wins over a simultaneous take.
    always_ff @(posedge CLK or posedge NRST) begin
        if (NRST) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (bus.IDRDY) begin
            r_hold      <= bus.IDATA;
            r_hold_full <= 1'b1;
        end else if (w_hold_take) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge NRST) begin
        if (NRST) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_phase   <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_odata   <= '0;
            r_odrdy   <= 1'b0;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
            r_stretch <= 2'd0;
`endif
        end else begin
            r_odrdy <= 1'b0;
            if (w_start || w_stop) begin
                r_state   <= w_start ? ST_ADDR : ST_IDLE;
                r_bitcnt  <= '0;
                r_phase   <= 1'b0;
                r_sda_oe  <= 1'b0;
                r_scl_oe  <= 1'b0;
                r_busy    <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                r_stretch <= 2'd0;
`endif
            end else if (w_load_req) begin
                r_state  <= ST_RD_DATA;
                r_bitcnt <= '0;
                r_phase  <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                if (!r_hold_full) begin
                    r_scl_oe  <= 1'b1;
                    r_sda_oe  <= 1'b0;
                    r_stretch <= 2'd1;
                end else
`endif
                begin
                    r_shift  <= w_load_val;
                    r_sda_oe <= ~w_load_val[7];
                end
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= {r_shift[6:0], w_sda};
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7) begin
                                if (r_shift[6:0] == TARGET_ADDR) begin
                                    r_state <= ST_ADDR_ACK;
                                    r_busy  <= 1'b1;
                                    r_rw    <= w_sda;
                                    r_phase <= 1'b0;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    // First SCL fall starts the ACK low, second ends it; the read
                    // case of the second fall is handled by the load path above.
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_phase  <= 1'b1;
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_phase  <= 1'b0;
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_WR_DATA;
                                r_bitcnt <= '0;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= {r_shift[6:0], w_sda};
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7) begin
                                r_odata <= {r_shift[6:0], w_sda};
                                r_odrdy <= 1'b1;
                                r_state <= ST_WR_ACK;
                                r_phase <= 1'b0;
                            end
                        end
                    end
                    ST_RD_DATA: begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
                        if (r_stretch == 2'd1) begin
                            if (r_hold_full) begin
                                r_shift   <= r_hold;
                                r_sda_oe  <= ~r_hold[7];
                                r_stretch <= 2'd2;
                            end
                        end else if (r_stretch == 2'd2) begin
                            r_scl_oe  <= 1'b0;
                            r_stretch <= 2'd0;
                        end else
`endif
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_RD_ACK;
                                r_phase  <= 1'b0;
                                r_bitcnt <= '0;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_phase <= 1'b1;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
                    default: begin
                        // IDLE and IGNORE only leave on START/STOP
                    end
                endcase
            end
        end
    end

    assign I2C_SDA   = r_sda_oe ? 1'b0 : 1'bz;
    assign I2C_SCL   = r_scl_oe ? 1'b0 : 1'bz;

    assign bus.ODATA = r_odata;
    assign bus.ODRDY = r_odrdy;
    assign bus.BUSY  = r_busy;
    assign bus.RW    = r_rw;
    assign bus.TREQ  = ~r_hold_full & r_rw &
                       ((r_state == ST_ADDR_ACK) | (r_state == ST_RD_DATA) | (r_state == ST_RD_ACK));

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target -- directed bench for i2c_target: a bit-banged I2C master
// drives the open-drain bus; expected received bytes (ODATA/ODRDY) and read
// bytes are queued by the stimulus and popped by separate monitor processes.
module tb_i2c_target;
    localparam time T = 200ns;  // quarter SCL period

    logic CLK      = 1'b0;
    logic NRST     = 1'b0;
    logic m_scl_oe = 1'b0;
    logic m_sda_oe = 1'b0;
    wire  scl;
    wire  sda;

    pullup (scl);
    pullup (sda);
    assign scl = m_scl_oe ? 1'b0 : 1'bz;
    assign sda = m_sda_oe ? 1'b0 : 1'bz;

    i2c_target_if bus_if ();

    i2c_target #(
        .TARGET_ADDR (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .CLK     (CLK),
        .NRST    (NRST),
        .I2C_SCL (scl),
        .I2C_SDA (sda),
        .bus     (bus_if)
    );

    always #5ns CLK = ~CLK;

    int         checks      = 0;
    int         errors      = 0;
    int         stretch_cyc = 0;
    logic       odrdy_prev  = 1'b0;
    logic [7:0] q_wr[$];
    logic [7:0] q_rd[$];
    logic [7:0] rd_byte;
    event       rd_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Receive-side monitor: every ODRDY pulse is matched against the queue.
    always @(negedge CLK) begin
        if (bus_if.ODRDY) begin
            check("odrdy_width", {31'd0, odrdy_prev}, 32'd0);
            if (q_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL odrdy_unexpected: ODATA=%02h, no write byte expected", bus_if.ODATA);
            end else begin
                check("odata", {24'd0, bus_if.ODATA}, {24'd0, q_wr.pop_front()});
            end
        end
        odrdy_prev = bus_if.ODRDY;
    end

    // Read-side monitor: each byte shifted out by the target.
    always begin
        @(rd_done);
        if (q_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got %02h, no read byte expected", rd_byte);
        end else begin
            check("rd_byte", {24'd0, rd_byte}, {24'd0, q_rd.pop_front()});
        end
    end

    // Cycles where SCL is low although the master has released it.
    always @(negedge CLK) begin
        if (!m_scl_oe && scl === 1'b0) stretch_cyc++;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: run exceeded 900us");
        $fatal(1, "watchdog expired");
    end

    task automatic align();
        @(posedge CLK);
        #1ns;
    endtask

    task automatic scl_release_wait();
        int n;
        n = 0;
        m_scl_oe = 1'b0;
        while (scl !== 1'b1 && n < 10000) begin
            @(posedge CLK);
            n++;
        end
        #1ns;
        if (scl !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL scl_timeout: SCL=%b, required 1 within 10000 cycles", scl);
        end
    endtask

    task automatic bus_bit(input logic b, output logic s);
        align();
        m_sda_oe = ~b;
        #T;
        scl_release_wait();
        #T;
        s = sda;
        #T;
        m_scl_oe = 1'b1;
        #T;
    endtask

    task automatic bus_start();
        align();
        m_sda_oe = 1'b0;
        #T;
        scl_release_wait();
        #T;
        m_sda_oe = 1'b1;
        #T;
        m_scl_oe = 1'b1;
        #T;
    endtask

    task automatic bus_stop();
        align();
        m_sda_oe = 1'b1;
        #T;
        scl_release_wait();
        #T;
        m_sda_oe = 1'b0;
        #T;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string name);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, s);
        check(name, {31'd0, s}, {31'd0, exp_ack});
    endtask

    task automatic read_byte(input logic nack);
        logic [7:0] v;
        logic       s;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            v = {v[6:0], s};
        end
        rd_byte = v;
        -> rd_done;
        bus_bit(nack, s);
    endtask

    task automatic idrdy_pulse(input logic [7:0] d);
        @(negedge CLK);
        bus_if.IDATA = d;
        bus_if.IDRDY = 1'b1;
        @(negedge CLK);
        bus_if.IDRDY = 1'b0;
    endtask

    initial begin
        logic s;
        bus_if.IDATA = '0;
        bus_if.IDRDY = 1'b0;
        #1ns;
        NRST = 1'b1;
        repeat (5) @(posedge CLK);
        #1ns;
        check("rst_odata", {24'd0, bus_if.ODATA}, 32'h00);
        check("rst_odrdy", {31'd0, bus_if.ODRDY}, 32'd0);
        check("rst_treq",  {31'd0, bus_if.TREQ},  32'd0);
        check("rst_busy",  {31'd0, bus_if.BUSY},  32'd0);
        check("rst_rw",    {31'd0, bus_if.RW},    32'd0);
        check("rst_sda",   {31'd0, sda},          32'd1);
        check("rst_scl",   {31'd0, scl},          32'd1);
        NRST = 1'b0;
        repeat (5) @(posedge CLK);

        // Write 0x50+W, 0xA5, STOP
        bus_start();
        write_byte(8'hA0, 1'b0, "ack_addr_w");
        check("busy_addressed", {31'd0, bus_if.BUSY}, 32'd1);
        check("rw_write",       {31'd0, bus_if.RW},   32'd0);
        q_wr.push_back(8'hA5);
        write_byte(8'hA5, 1'b0, "ack_data_a5");
        bus_stop();
        check("busy_after_stop", {31'd0, bus_if.BUSY}, 32'd0);

        // Preloaded read of 0x55, master NACK, STOP
        idrdy_pulse(8'h55);
        check("treq_idle_loaded", {31'd0, bus_if.TREQ}, 32'd0);
        bus_start();
        write_byte(8'hA1, 1'b0, "ack_addr_r");
        check("treq_after_load", {31'd0, bus_if.TREQ}, 32'd1);
        check("rw_read",         {31'd0, bus_if.RW},   32'd1);
        q_rd.push_back(8'h55);
        read_byte(1'b1);
        check("busy_ignore",         {31'd0, bus_if.BUSY}, 32'd1);
        check("treq_ignore",         {31'd0, bus_if.TREQ}, 32'd0);
        check("sda_released_ignore", {31'd0, sda},         32'd1);
        bus_stop();
        check("busy_after_stop_r", {31'd0, bus_if.BUSY}, 32'd0);

        // Wrong address 0x51: no ACK anywhere, no ODRDY
        bus_start();
        write_byte(8'hA2, 1'b1, "nack_addr_51");
        check("busy_mismatch", {31'd0, bus_if.BUSY}, 32'd0);
        write_byte(8'h3C, 1'b1, "nack_data_3c");
        bus_stop();
        check("odata_mismatch_kept", {24'd0, bus_if.ODATA}, 32'hA5);

        // Write 0x12, repeated START, read 0x34
        bus_start();
        write_byte(8'hA0, 1'b0, "ack_addr_w2");
        q_wr.push_back(8'h12);
        write_byte(8'h12, 1'b0, "ack_data_12");
        check("rw_before_rstart", {31'd0, bus_if.RW}, 32'd0);
        bus_start();
        check("busy_rstart", {31'd0, bus_if.BUSY}, 32'd0);
        idrdy_pulse(8'h34);
        write_byte(8'hA1, 1'b0, "ack_addr_r2");
        check("rw_after_rstart", {31'd0, bus_if.RW}, 32'd1);
        q_rd.push_back(8'h34);
        read_byte(1'b1);
        bus_stop();
        check("odata_after_read", {24'd0, bus_if.ODATA}, 32'h12);

        // Read with empty holding register
        stretch_cyc = 0;
        bus_start();
        write_byte(8'hA1, 1'b0, "ack_addr_r3");
`ifdef I2C_TARGET_CLK_STRETCH_EN
        q_rd.push_back(8'h9A);
        fork
            begin
                #25us;
                check("treq_stretch", {31'd0, bus_if.TREQ}, 32'd1);
                #25us;
                idrdy_pulse(8'h9A);
            end
            read_byte(1'b1);
        join
        bus_stop();
        check("stretch_50us", {31'd0, (stretch_cyc >= 4500) && (stretch_cyc <= 5300)}, 32'd1);
`else
        check("treq_empty", {31'd0, bus_if.TREQ}, 32'd1);
        q_rd.push_back(8'hFF);
        read_byte(1'b1);
        bus_stop();
        check("scl_never_driven", stretch_cyc, 32'd0);
`endif

        // Reset during bit 4 of a write, then a clean write of 0x77
        bus_start();
        write_byte(8'hA0, 1'b0, "ack_addr_pre_reset");
        bus_bit(1'b1, s);
        bus_bit(1'b1, s);
        bus_bit(1'b0, s);
        align();
        m_sda_oe = 1'b1;
        #T;
        scl_release_wait();
        #T;
        NRST = 1'b1;
        #1ns;
        check("midrst_odata", {24'd0, bus_if.ODATA}, 32'h00);
        check("midrst_odrdy", {31'd0, bus_if.ODRDY}, 32'd0);
        check("midrst_treq",  {31'd0, bus_if.TREQ},  32'd0);
        check("midrst_busy",  {31'd0, bus_if.BUSY},  32'd0);
        check("midrst_rw",    {31'd0, bus_if.RW},    32'd0);
        #T;
        m_scl_oe = 1'b1;
        #T;
        NRST = 1'b0;
        bus_bit(1'b0, s);
        bus_bit(1'b0, s);
        bus_bit(1'b1, s);
        bus_bit(1'b1, s);
        bus_bit(1'b1, s);
        check("no_ack_after_reset", {31'd0, s}, 32'd1);
        check("busy_after_reset",   {31'd0, bus_if.BUSY}, 32'd0);
        bus_start();
        write_byte(8'hA0, 1'b0, "ack_addr_post_reset");
        q_wr.push_back(8'h77);
        write_byte(8'h77, 1'b0, "ack_data_77");
        bus_stop();
        check("odata_77", {24'd0, bus_if.ODATA}, 32'h77);

        repeat (10) @(posedge CLK);
        check("wr_queue_drained", q_wr.size(), 32'd0);
        check("rd_queue_drained", q_rd.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
